logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//   Shares one registered WIDTH-bit bitwise logic datapath (AND/OR/XOR/ANDN) between two
//   requesters: port 0 = EX-stage ALU, port 1 = branch-predictor / CSR side path.
//   Round-robin arbitration, valid/ready on both sides, one output register slot.
//   Sits beside the EX stage; result returns tagged with the requester id.
// PARAMETERS
//   WIDTH     32   operand / result width in bits
//   CNT_W     8    width of the saturating stall counter
// PORTS
//   clk_i          in   1      clock, all state on rising edge
//   rst_ni         in   1      asynchronous active-low reset
//   req0_valid_i   in   1      requester 0 has an operation
//   req0_ready_o   out  1      requester 0 operation accepted this cycle
//   req0_op_i      in   2      00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b)
//   req0_a_i       in   WIDTH  operand a
//   req0_b_i       in   WIDTH  operand b
//   req1_valid_i   in   1      requester 1 has an operation
//   req1_ready_o   out  1      requester 1 operation accepted this cycle
//   req1_op_i      in   2      as req0_op_i
//   req1_a_i       in   WIDTH  operand a
//   req1_b_i       in   WIDTH  operand b
//   rsp_valid_o    out  1      result register holds a valid result
//   rsp_ready_i    in   1      consumer takes result this cycle
//   rsp_id_o       out  1      requester that issued the held result
//   rsp_data_o     out  WIDTH  held result
//   stall_cnt_o    out  CNT_W  cycles with rsp_valid_o=1 and rsp_ready_i=0, saturating
// BEHAVIOUR
//   - Reset (rst_ni=0, async): rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, stall_cnt_o=0,
//     prio_q=0 (requester 0 preferred). In-flight result is discarded; no replay.
//   - Slot states: EMPTY (rsp_valid_o=0) / FULL (rsp_valid_o=1).
//     slot_free = EMPTY | (FULL & rsp_ready_i).
//   - Grant (combinational): only one valid -> that one; both valid -> requester prio_q.
//     reqX_ready_o = slot_free & reqX_valid_i & (grant==X); never both high.
//     Ready may depend on valid; requesters must not make valid depend on ready.
//   - Accept when reqX_valid_i & reqX_ready_o at edge N: edge N loads rsp_data_o = op(a,b),
//     rsp_id_o = X, rsp_valid_o = 1; result visible cycle N+1 (latency 1).
//   - prio_q <= ~X on every accept from X; unchanged when nothing is accepted.
//   - FULL & rsp_ready_i & new accept: same edge retires old result, loads new one;
//     back-to-back throughput 1 op/cycle, no bubble.
//   - FULL & rsp_ready_i & no accept -> EMPTY. FULL & !rsp_ready_i -> hold; rsp_* stable.
//   - EMPTY: rsp_data_o / rsp_id_o hold last value (don't care to consumer).
//   - stall_cnt_o: +1 per FULL & !rsp_ready_i cycle, saturates at 2^CNT_W-1, clears only
//     on reset.
//   - Width rules: pure bitwise, no carry; ANDN = a & ~b per bit; op codes are all legal.
//   - Requester holding valid while not granted must keep op/a/b stable (checked by bench).
// TESTING
//   1 Reset then req0 AND a=F0F0_F0F0 b=FF00_FF00, rsp_ready_i=1 -> next cycle
//     rsp_valid_o=1, rsp_id_o=0, rsp_data_o=F000_F000.
//   2 Both valid every cycle, rsp_ready_i=1 -> grants alternate 0,1,0,1...; req1 XOR
//     a=FFFF_0000 b=0F0F_0F0F -> rsp_data_o=F0F0_0F0F, rsp_id_o=1.
//   3 rsp_ready_i=0 for 5 cycles with result held -> both readies low, rsp_* stable,
//     stall_cnt_o=5; release -> next accepted op appears 1 cycle later.
//   4 Stall 300 cycles with CNT_W=8 -> stall_cnt_o sticks at 255.
//   5 req1 ANDN a=FFFF_FFFF b=0000_00FF -> FFFF_FF00; req0 OR 0x1 | 0x8000_0000 -> 8000_0001.
//   6 Assert rst_ni=0 mid-stream while FULL -> rsp_valid_o=0 immediately (async),
//     stall_cnt_o=0, next contested grant goes to requester 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared, registered bitwise logic unit.
// One result slot; results return tagged with the id of the requester that issued them.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [1:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [1:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  localparam logic [1:0]       OP_AND  = 2'b00;
  localparam logic [1:0]       OP_OR   = 2'b01;
  localparam logic [1:0]       OP_XOR  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & ~b;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  slot_e            slot_p0;
  slot_e            slot_d;
  logic             prio_p0;
  logic             grant;
  logic             slot_free;
  logic             accept;
  logic             load_p0;
  logic             stall_evt;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] rsp_data_p0;
  logic             rsp_id_p0;
  logic [CNT_W-1:0] stall_cnt_p0;

  // A lone requester always wins; a contested cycle goes to the one prio_p0 points at.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant = prio_p0;
    end else if (req1_valid_i) begin
      grant = 1'b1;
    end
  end

  assign slot_free    = (slot_p0 == EMPTY) || rsp_ready_i;
  assign req0_ready_o = slot_free & req0_valid_i & ~grant;
  assign req1_ready_o = slot_free & req1_valid_i & grant;
  assign accept       = req0_ready_o | req1_ready_o;

  always_comb begin
    sel_op = req0_op_i;
    sel_a  = req0_a_i;
    sel_b  = req0_b_i;
    if (grant) begin
      sel_op = req1_op_i;
      sel_a  = req1_a_i;
      sel_b  = req1_b_i;
    end
  end

  assign result_d = logic_op(sel_op, sel_a, sel_b);

  // Slot state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_p0 <= EMPTY;
    end else begin
      slot_p0 <= slot_d;
    end
  end

  // A retiring result and a new accept share one edge, so FULL can stay FULL.
  always_comb begin
    slot_d = slot_p0;
    case (slot_p0)
      EMPTY: begin
        if (accept) slot_d = FULL;
      end
      FULL: begin
        if (accept)           slot_d = FULL;
        else if (rsp_ready_i) slot_d = EMPTY;
      end
      default: slot_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid_o = (slot_p0 == FULL);
    load_p0     = accept;
    stall_evt   = (slot_p0 == FULL) && !rsp_ready_i;
  end

  // Result register stage; contents are left untouched while EMPTY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_data_p0 <= '0;
      rsp_id_p0   <= 1'b0;
    end else if (load_p0) begin
      rsp_data_p0 <= result_d;
      rsp_id_p0   <= grant;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_p0 <= 1'b0;
    end else if (accept) begin
      prio_p0 <= ~grant;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_p0 <= '0;
    end else if (stall_evt) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign rsp_data_o  = rsp_data_p0;
  assign rsp_id_o    = rsp_id_p0;
  assign stall_cnt_o = stall_cnt_p0;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the slot, round-robin priority and stall counter.
module tb_logic_unit_arbiter;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             v0, v1, rdy0, rdy1, rsp_valid, rsp_rdy, rsp_id;
  logic [1:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1, rsp_data;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic             m_valid, m_id, m_prio;
  logic [WIDTH-1:0] m_data;
  int               m_stall;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .stall_cnt_o(stall_cnt)
  );

  // Per-bit truth tables indexed by {a,b}: AND, OR, XOR, ANDN.
  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [3:0] tt [4];
    logic [3:0] t;
    logic [WIDTH-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0100;
    t = tt[op];
    for (int i = 0; i < WIDTH; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic exp_grant();
    if (v0 && v1) return m_prio;
    return v1;
  endfunction

  function automatic logic exp_rdy0();
    return (!m_valid || rsp_rdy) && v0 && !exp_grant();
  endfunction

  function automatic logic exp_rdy1();
    return (!m_valid || rsp_rdy) && v1 && exp_grant();
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_prio = 1'b0; m_data = '0; m_stall = 0;
  endtask

  // Advance the model over the coming edge using the inputs currently driven.
  task automatic tick();
    logic x0, x1;
    x0 = exp_rdy0();
    x1 = exp_rdy1();
    if (m_valid && !rsp_rdy && m_stall < CNT_MAX) m_stall++;
    if (x0 || x1) begin
      m_valid = 1'b1;
      m_id    = x1;
      m_data  = x1 ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
      m_prio  = !x1;
    end else if (m_valid && rsp_rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 0; v1 = 0; rsp_rdy = 1'b1;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_id got %b want 0", rsp_id); end
    n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", rsp_data); end
    n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    n_cmp++; if ({rdy0, rdy1} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", {rdy0, rdy1}); end
    @(posedge clk); #1;
  endtask

  task automatic test_and_basic();
    v0 = 1; op0 = 2'b00; a0 = 32'hF0F0_F0F0; b0 = 32'hFF00_FF00; rsp_rdy = 1;
    #2;
    n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL basic_rdy0 got %b want 1", rdy0); end
    tick();
    v0 = 0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL basic_id got %b want 0", rsp_id); end
    n_cmp++; if (rsp_data !== 32'hF000_F000) begin n_err++; $display("FAIL basic_data got %h want F000F000", rsp_data); end
  endtask

  task automatic test_alternate();
    logic g;
    v0 = 1; op0 = 2'b01; a0 = 32'h0000_00F0; b0 = 32'h0000_0F00;
    v1 = 1; op1 = 2'b10; a1 = 32'hFFFF_0000; b1 = 32'h0F0F_0F0F;
    rsp_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 0);
      #2;
      n_cmp++; if ({rdy1, rdy0} !== {g, !g}) begin n_err++; $display("FAIL alt_ready[%0d] got %b want %b", i, {rdy1, rdy0}, {g, !g}); end
      tick();
      n_cmp++; if (rsp_id !== g) begin n_err++; $display("FAIL alt_id[%0d] got %b want %b", i, rsp_id, g); end
      n_cmp++; if (rsp_data !== (g ? 32'hF0F0_0F0F : 32'h0000_0FF0)) begin
        n_err++; $display("FAIL alt_data[%0d] got %h want %h", i, rsp_data, g ? 32'hF0F0_0F0F : 32'h0000_0FF0);
      end
    end
  endtask

  task automatic test_stall();
    rsp_rdy = 0; v0 = 0; v1 = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_cmp++; if ({rdy0, rdy1} !== 2'b00) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 00", i, {rdy0, rdy1}); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_data !== m_data) begin
        n_err++; $display("FAIL stall_hold[%0d] got %b/%b/%h want 1/%b/%h", i, rsp_valid, rsp_id, rsp_data, m_id, m_data);
      end
      tick();
    end
    n_cmp++; if (stall_cnt !== 8'd5) begin n_err++; $display("FAIL stall_cnt5 got %0d want 5", stall_cnt); end
    v1 = 0; v0 = 1; op0 = 2'b00; a0 = 32'hF0F0_F0F0; b0 = 32'hFF00_FF00; rsp_rdy = 1;
    #2;
    n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL release_rdy0 got %b want 1", rdy0); end
    tick();
    v0 = 0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'hF000_F000) begin
      n_err++; $display("FAIL release_rsp got %b/%b/%h want 1/0/F000F000", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_saturate();
    rsp_rdy = 0;
    repeat (248) tick();
    n_cmp++; if (stall_cnt !== 8'd253) begin n_err++; $display("FAIL sat_pre got %0d want 253", stall_cnt); end
    repeat (52) tick();
    n_cmp++; if (stall_cnt !== 8'd255) begin n_err++; $display("FAIL sat_stick got %0d want 255", stall_cnt); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid got %b want 1", rsp_valid); end
  endtask

  task automatic test_andn_or();
    rsp_rdy = 1;
    v1 = 1; op1 = 2'b11; a1 = 32'hFFFF_FFFF; b1 = 32'h0000_00FF;
    tick();
    v1 = 0;
    n_cmp++; if (rsp_id !== 1'b1 || rsp_data !== 32'hFFFF_FF00) begin
      n_err++; $display("FAIL andn got %b/%h want 1/FFFFFF00", rsp_id, rsp_data);
    end
    v0 = 1; op0 = 2'b01; a0 = 32'h0000_0001; b0 = 32'h8000_0000;
    tick();
    v0 = 0;
    n_cmp++; if (rsp_id !== 1'b0 || rsp_data !== 32'h8000_0001) begin
      n_err++; $display("FAIL or got %b/%h want 0/80000001", rsp_id, rsp_data);
    end
  endtask

  task automatic test_random();
    logic keep0, keep1;
    for (int i = 0; i < 400; i++) begin
      #2;
      n_cmp++; if (rdy0 !== exp_rdy0() || rdy1 !== exp_rdy1()) begin
        n_err++; $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, rdy0, rdy1, exp_rdy0(), exp_rdy1());
      end
      n_cmp++; if (rsp_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, rsp_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (rsp_id !== m_id || rsp_data !== m_data) begin
          n_err++; $display("FAIL rnd_rsp[%0d] got %b/%h want %b/%h", i, rsp_id, rsp_data, m_id, m_data);
        end
      end
      n_cmp++; if (int'(stall_cnt) !== m_stall) begin n_err++; $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_cnt, m_stall); end
      keep0 = v0 && !exp_rdy0();
      keep1 = v1 && !exp_rdy1();
      tick();
      if (!keep0) begin
        v0 = ($urandom_range(0, 3) != 0); op0 = 2'($urandom); a0 = $urandom; b0 = $urandom;
      end
      if (!keep1) begin
        v1 = ($urandom_range(0, 3) != 0); op1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
    end
    v0 = 0; v1 = 0; rsp_rdy = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    v0 = 1; op0 = 2'b10; a0 = 32'h1234_5678; b0 = 32'hFFFF_FFFF; rsp_rdy = 0;
    tick();
    v0 = 0;
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || stall_cnt === '0) begin
      n_err++; $display("FAIL mid_pre got valid %b stall %0d want 1 and nonzero", rsp_valid, stall_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b want 0", rsp_valid); end
    n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL mid_async_stall got %0d want 0", stall_cnt); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    v0 = 1; v1 = 1; rsp_rdy = 1;
    op0 = 2'b00; a0 = 32'hAAAA_AAAA; b0 = 32'h0F0F_0F0F;
    op1 = 2'b01; a1 = 32'h0; b1 = 32'h1;
    #2;
    n_cmp++; if ({rdy0, rdy1} !== 2'b10) begin n_err++; $display("FAIL mid_grant got %b want 10", {rdy0, rdy1}); end
    tick();
    v0 = 0; v1 = 0;
    n_cmp++; if (rsp_id !== 1'b0 || rsp_data !== 32'h0A0A_0A0A) begin
      n_err++; $display("FAIL mid_rsp got %b/%h want 0/0A0A0A0A", rsp_id, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_and_basic();
    test_alternate();
    test_stall();
    test_saturate();
    test_andn_or();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
